// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, fixed 33-cycle latency from acceptance to the done pulse.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  result_rd
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] opnd_q;
  logic [63:0] acc_q;
  logic        neg_res_q, neg_rem_q, div_zero_q, ovf_q;

  logic        signed_a, signed_b, sign_a, sign_b;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] mul_next, div_next, prod;
  logic [31:0] quo, rem, res_final;

  always_comb begin
    signed_a = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    signed_b = funct3[2] ? ~funct3[0] : ~funct3[1];
    sign_a   = signed_a & rs1_data[31];
    sign_b   = signed_b & rs2_data[31];
    a_mag    = sign_a ? -rs1_data : rs1_data;
    b_mag    = sign_b ? -rs2_data : rs2_data;
  end

  // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
  // Divide: acc holds {partial remainder, remaining dividend bits / quotient bits}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_shift >= {1'b0, opnd_q}) begin
      div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
    end
  end

  always_comb begin
    prod      = neg_res_q ? -acc_q : acc_q;
    quo       = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
    rem       = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
    res_final = '0;
    if (!op_q[2]) begin
      res_final = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end else if (!op_q[1]) begin
      if (div_zero_q)  res_final = 32'hFFFF_FFFF;
      else if (ovf_q)  res_final = 32'h8000_0000;
      else             res_final = quo;
    end else begin
      // Divide-by-zero leaves the full dividend in the remainder, so only overflow needs forcing.
      res_final = ovf_q ? 32'h0 : rem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      result_rd  <= '0;
    end else if (kill) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state_q    <= StRun;
            busy       <= 1'b1;
            cnt_q      <= '0;
            op_q       <= funct3;
            rd_q       <= rd;
            opnd_q     <= funct3[2] ? b_mag : a_mag;
            acc_q      <= {32'h0, funct3[2] ? a_mag : b_mag};
            neg_res_q  <= sign_a ^ sign_b;
            neg_rem_q  <= sign_a;
            div_zero_q <= (rs2_data == 32'h0);
            ovf_q      <= signed_a && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
          end else begin
            busy <= 1'b0;
          end
        end
        StRun: begin
          acc_q <= op_q[2] ? div_next : mul_next;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= StDone;
        end
        StDone: begin
          // busy stays high through the done pulse; IDLE then clears it or re-accepts.
          result    <= res_final;
          result_rd <= rd_q;
          done      <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, control corner cases and
// randomized operations compared against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  result_rd;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd       (rd),
    .kill     (kill),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .result_rd(result_rd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  // Waits (bounded) until the unit can accept, then presents one operation for a single edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r);
    int n = 0;
    while (busy && !done && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("accept_timeout", {31'h0, busy}, 32'h0);
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd       = r;
    start    = 1'b1;
    tick();
    check("accept_busy_done", {30'h0, busy, done}, 32'd2);
    start    = 1'b0;
    funct3   = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd       = 5'($urandom);
  endtask

  // Runs the 33 edges after acceptance; poke>0 pulses a stray start on that edge.
  task automatic complete(input string tag, input logic [31:0] exp, input logic [4:0] r,
                          input bit chain, input int poke);
    bit ok = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (i == poke) begin
        start    = 1'b1;
        funct3   = 3'd4;
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd       = ~r;
      end
      tick();
      start = 1'b0;
      if (!(busy === 1'b1 && done === 1'b0)) ok = 1'b0;
    end
    check({tag, "_run_window"}, {31'h0, ok}, 32'h1);
    tick();
    check({tag, "_done"}, {30'h0, busy, done}, 32'd3);
    check({tag, "_result"}, result, exp);
    check({tag, "_rd"}, {27'h0, result_rd}, {27'h0, r});
    last_res = exp;
    last_rd  = r;
    if (!chain) begin
      tick();
      check({tag, "_idle"}, {30'h0, busy, done}, 32'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                        input bit chain);
    issue(f, a, b, r);
    complete(tag, exp, r, chain, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  r;
    rst = 1'b1; start = 1'b0; kill = 1'b0;
    funct3 = '0; rs1_data = '0; rs2_data = '0; rd = '0;
    tick();
    tick();
    check("reset_ctrl", {30'h0, busy, done}, 32'd0);
    check("reset_result", result, 32'h0);
    check("reset_rd", {27'h0, result_rd}, 32'h0);
    rst = 1'b0;
    tick();

    run_op("mul_7_m6", 3'd0, 32'd7, 32'hFFFF_FFFA, 5'd5, 32'hFFFF_FFD6, 1'b0);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 1'b0);
    run_op("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 1'b0);
    run_op("mulhsu_min", 3'd2, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'hC000_0000, 1'b0);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 1'b0);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd12, 32'd2, 1'b0);
    run_op("divu_by0", 3'd5, 32'h1234, 32'h0, 5'd13, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_by0", 3'd6, 32'h1234, 32'h0, 5'd14, 32'h1234, 1'b0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0, 1'b0);

    // Stray start at cycle 10 must not disturb the in-flight multiply.
    issue(3'd0, 32'd1000, 32'd3000, 5'd17);
    complete("start_ignored", 32'd3_000_000, 5'd17, 1'b0, 10);

    // Kill at cycle 20: no done, previous result held, restart accepted at cycle 21.
    issue(3'd5, 32'd999, 32'd3, 5'd18);
    ok = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (done !== 1'b0) ok = 1'b0;
    end
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_no_done", {31'h0, ok}, 32'h1);
    check("kill_ctrl", {30'h0, busy, done}, 32'd0);
    check("kill_result_held", result, last_res);
    check("kill_rd_held", {27'h0, result_rd}, {27'h0, last_rd});
    run_op("after_kill", 3'd7, 32'd999, 32'd4, 5'd19, 32'd3, 1'b0);

    // Kill together with start in IDLE must not accept.
    start = 1'b1; kill = 1'b1; funct3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd5;
    tick();
    start = 1'b0; kill = 1'b0;
    check("kill_start_rejected", {30'h0, busy, done}, 32'd0);
    tick();
    check("kill_start_still_idle", {30'h0, busy, done}, 32'd0);

    // Reset at cycle 15 of an operation clears everything.
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20);
    for (int i = 1; i <= 14; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ctrl", {30'h0, busy, done}, 32'd0);
    check("midrst_result", result, 32'h0);
    check("midrst_rd", {27'h0, result_rd}, 32'h0);

    // Back-to-back: next start accepted on the edge right after done.
    run_op("b2b_first", 3'd0, 32'd12, 32'd13, 5'd21, 32'd156, 1'b1);
    run_op("b2b_second", 3'd4, 32'hFFFF_FF00, 32'd16, 5'd22, 32'hFFFF_FFF0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      r = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        3: b = 32'($signed(-$urandom_range(1, 50)));
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d", n, f), f, a, b, r, ref_model(f, a, b),
             bit'($urandom_range(0, 1)));
    end
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
